gpr_file_sb: RTL and testbench
==============================

GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports (>=1).
REQ-004 SHALL have parameter NWP, default 2, meaning number of write ports (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rd_addr  input  NRP*AW  packed read addresses, port p at bits [p*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRP*XLEN  packed read data, port p at bits [p*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy  output  NRP  per-read-port scoreboard busy flag of the addressed register.
REQ-010 SHALL have port wr_en  input  NWP  per-write-port enable.
REQ-011 SHALL have port wr_addr  input  NWP*AW  packed write addresses.
REQ-012 SHALL have port wr_data  input  NWP*XLEN  packed write data.
REQ-013 SHALL have port iss_en  input  1  issue strobe: mark iss_rd as pending.
REQ-014 SHALL have port iss_rd  input  AW  destination register being issued.
REQ-015 SHALL have port flush  input  1  clear all pending (busy) marks.
REQ-016 SHALL have port busy_any  output  1  registered OR of all busy bits.

Function
REQ-017 SHALL treat register 0 as hardwired zero: reads return 0, writes ignored, busy bit never set.
REQ-018 SHALL update register wr_addr[w] with wr_data[w] on the clock edge where wr_en[w]=1 and wr_addr[w]!=0.
REQ-019 SHALL resolve same-cycle writes to one address by highest-index write port winning.
REQ-020 SHALL return rd_data combinationally (zero-cycle latency) with write-first bypass: a same-cycle enabled write to the read address (nonzero) forwards its wr_data, highest-index port winning.
REQ-021 SHALL hold busy[r] set from the edge after iss_en=1 with iss_rd=r (r!=0) until cleared.
REQ-022 SHALL clear busy[r] on the edge where any write port writes r, unless iss_en targets r in the same cycle, in which case busy[r] stays set.
REQ-023 SHALL clear all busy bits on an edge with flush=1; a simultaneous iss_en to r!=0 leaves only busy[r] set after that edge.
REQ-024 SHALL drive rd_busy[p] combinationally as busy[rd_addr[p]], forced 0 when the same cycle has an enabled write to rd_addr[p] (bypass hit) and no iss_en to it.
REQ-025 SHALL register busy_any one cycle after the busy vector (busy_any reflects busy state at the previous edge's result).
REQ-026 SHALL ignore X on wr_data/wr_addr for ports whose wr_en=0.

Reset
REQ-027 SHALL, on any edge with rst=1, clear all registers to 0, all busy bits to 0 and busy_any to 0, overriding writes, issue and flush that cycle.
REQ-028 SHALL, during reset cycles, drive rd_data with the post-reset-or-current register contents without bypass of blocked writes (bypass disabled while rst=1).
REQ-029 SHALL resume normal operation on the first edge with rst=0; a reset asserted mid-stream discards all pending marks.

Structure
REQ-030 SHALL place XLEN/NREG defaults, the zero-register index and the register reset value constant in the shared defines package.
REQ-031 SHALL instantiate one sub-module gpr_bypass_mux per read port (inputs: register-array value, all write ports, read address; outputs: data and hit flag).
REQ-032 SHALL keep the register array and busy vector in gpr_file_sb only.

Verification
REQ-033 SHALL cover: wr_en=01, wr_addr0=5, wr_data0=0xDEADBEEF, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF that cycle and thereafter.
REQ-034 SHALL cover: both write ports write reg 7 (0x11, 0x22) same cycle -> reg 7 reads 0x22; write 0x55 to reg 0 -> reg 0 reads 0.
REQ-035 SHALL cover: iss_en, iss_rd=3 -> rd_busy=1 for rd_addr=3 next cycle, busy_any=1 one cycle later; write reg 3 -> rd_busy=0 same cycle (bypass), busy bit 0 after edge.
REQ-036 SHALL cover: iss_en iss_rd=9 with write to reg 9 same cycle -> busy[9] stays 1; flush with iss_rd=4 -> only busy[4]=1.
REQ-037 SHALL cover: registers 1..31 written and busy 2,6 set, then rst=1 for one cycle alongside a write to reg 1 -> all reads 0, rd_busy 0, busy_any 0 two cycles later.
REQ-038 SHALL cover: NRP=4, NWP=1, NREG=16 build -> all four ports read distinct registers correctly.

Source files
------------

// File: rtl/gpr_file_sb_pkg.sv
// Shared defines for the scoreboarded general-purpose register file:
// default geometry, the hardwired-zero register index and the register reset value.
package gpr_file_sb_pkg;

  localparam int GPR_XLEN     = 32;
  localparam int GPR_NREG     = 32;
  localparam int GPR_ZERO_REG = 0;
  localparam bit GPR_RST_BIT  = 1'b0;  // replicated to XLEN bits at use sites

endpackage : gpr_file_sb_pkg

// File: rtl/gpr_file_sb_bypass_mux.sv
// Per-read-port write-first bypass: forwards the highest-index enabled write
// to the read address, otherwise passes the stored register value through.
module gpr_bypass_mux
  import gpr_file_sb_pkg::*;
#(
  parameter int XLEN = GPR_XLEN,
  parameter int AW   = 5,
  parameter int NWP  = 2
) (
  input  logic [XLEN-1:0]     reg_val,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [XLEN-1:0]     rd_data,
  output logic                hit
);

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a read
    // with no matching write would hold its old value and infer a latch.
    rd_data = reg_val;
    hit     = 1'b0;
    // Ascending scan so the highest-index matching port is applied last.
    for (int w = 0; w < NWP; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr) &&
          (rd_addr != AW'(GPR_ZERO_REG))) begin
        rd_data = wr_data[w*XLEN +: XLEN];
        hit     = 1'b1;
      end
    end
  end

endmodule : gpr_bypass_mux

// File: rtl/gpr_file_sb.sv
// Multi-ported register file with hardwired-zero r0, write-first read bypass
// and a per-register pending (busy) scoreboard driven by issue/write/flush.
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter  int XLEN = GPR_XLEN,
  parameter  int NREG = GPR_NREG,
  parameter  int NRP  = 2,
  parameter  int NWP  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                busy_any
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(GPR_ZERO_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NWP-1:0]  byp_wr_en;

  // Writes blocked by reset must not be visible through the bypass either.
  assign byp_wr_en = wr_en & {NWP{~rst}};

  always_comb begin
    busy_nxt = flush ? '0 : busy;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    // Issue is applied last so it wins over a same-cycle write or flush.
    if (iss_en && (iss_rd != ZERO_IDX)) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because architectural state must
      // read as zero after reset; state uses non-blocking assignments only.
      for (int r = 0; r < NREG; r++) regs[r] <= {XLEN{GPR_RST_BIT}};
      busy     <= '0;
      busy_any <= 1'b0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != ZERO_IDX))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
      busy     <= busy_nxt;
      busy_any <= |busy;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra = rd_addr[p*AW +: AW];

    gpr_bypass_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWP  (NWP)
    ) u_bypass_mux (
      .reg_val (regs[ra]),
      .wr_en   (byp_wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (ra),
      .rd_data (rd_data[p*XLEN +: XLEN]),
      .hit     (hit)
    );

    // A bypassed write retires the pending mark unless it is re-issued now.
    assign rd_busy[p] = busy[ra] & ~(hit & ~(iss_en && (iss_rd == ra)));
  end

endmodule : gpr_file_sb

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_gpr_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        busy_any;

  logic [15:0]  s_rd_addr;
  logic [127:0] s_rd_data;
  logic [3:0]   s_rd_busy;
  logic [0:0]   s_wr_en;
  logic [3:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic         s_iss_en;
  logic [3:0]   s_iss_rd;
  logic         s_flush;
  logic         s_busy_any;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];
  bit          mbusy_any;

  always #5 clk = ~clk;

  gpr_file_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_rd(iss_rd), .flush(flush), .busy_any(busy_any)
  );

  gpr_file_sb #(.XLEN(32), .NREG(16), .NRP(4), .NWP(1)) dut_small (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .iss_en(s_iss_en),
    .iss_rd(s_iss_rd), .flush(s_flush), .busy_any(s_busy_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit write_hits(input int a, output logic [31:0] v);
    bit h = 0;
    v = mregs[a];
    if (!rst && a != 0)
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && int'(wr_addr[w*5 +: 5]) == a) begin
          h = 1;
          v = wr_data[w*32 +: 32];
        end
    return h;
  endfunction

  task automatic model_check();
    for (int p = 0; p < 2; p++) begin
      int a = int'(rd_addr[p*5 +: 5]);
      logic [31:0] v;
      bit h = write_hits(a, v);
      bit eb = mbusy[a] && !(h && !(iss_en && int'(iss_rd) == a));
      chk($sformatf("rd_data%0d[r%0d]", p, a), rd_data[p*32 +: 32], v);
      chk($sformatf("rd_busy%0d[r%0d]", p, a), {31'd0, rd_busy[p]}, {31'd0, eb});
    end
    chk("busy_any", {31'd0, busy_any}, {31'd0, mbusy_any});
  endtask

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mregs[r] = '0;
        mbusy[r] = 0;
      end
      mbusy_any = 0;
    end else begin
      bit any = 0;
      for (int r = 0; r < 32; r++) any |= mbusy[r];
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w*5 +: 5] != 0) mregs[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
      if (flush) for (int r = 0; r < 32; r++) mbusy[r] = 0;
      for (int w = 0; w < 2; w++) if (wr_en[w]) mbusy[wr_addr[w*5 +: 5]] = 0;
      if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1;
      mbusy_any = any;
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared 2 time units later.
  task automatic cycle();
    #2;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_rd = '0; flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle(); rd_addr = '0;
    s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
    s_iss_en = 0; s_iss_rd = '0; s_flush = 0;
    repeat (2) @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 0;
    rd_addr = {5'd31, 5'd1};
    cycle();

    // Write-first bypass, then persistence.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rd_addr = {5'd0, 5'd5};
    #1 chk("bypass_r5", rd_data[31:0], 32'hDEADBEEF);
    cycle();
    idle();
    #1 chk("stored_r5", rd_data[31:0], 32'hDEADBEEF);
    cycle();

    // Same-cycle collision: port 1 wins; writes to r0 ignored.
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd0, 5'd7};
    cycle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h55}; rd_addr = {5'd0, 5'd7};
    #1 chk("r0_bypass", rd_data[63:32], 32'h0);
    cycle();
    idle();
    #1 chk("collide_r7", rd_data[31:0], 32'h22);
    chk("r0_zero", rd_data[63:32], 32'h0);
    cycle();

    // Issue r3: busy next cycle, busy_any one cycle later, cleared by a write.
    iss_en = 1; iss_rd = 5'd3; rd_addr = {5'd0, 5'd3};
    cycle();
    idle();
    #1 chk("busy_r3", {31'd0, rd_busy[0]}, 32'd1);
    chk("busy_any_lag", {31'd0, busy_any}, 32'd0);
    cycle();
    #1 chk("busy_any_r3", {31'd0, busy_any}, 32'd1);
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h3333, 32'h0};
    #1 chk("busy_r3_bypass", {31'd0, rd_busy[0]}, 32'd0);
    cycle();
    idle();
    #1 chk("busy_r3_cleared", {31'd0, rd_busy[0]}, 32'd0);
    cycle();

    // Issue beats same-cycle write; flush plus issue leaves only the new mark.
    iss_en = 1; iss_rd = 5'd9; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
    rd_addr = {5'd4, 5'd9};
    cycle();
    idle();
    #1 chk("busy_r9_kept", {31'd0, rd_busy[0]}, 32'd1);
    flush = 1; iss_en = 1; iss_rd = 5'd4;
    cycle();
    idle();
    #1 chk("flush_r9", {31'd0, rd_busy[0]}, 32'd0);
    chk("flush_iss_r4", {31'd0, rd_busy[1]}, 32'd1);
    cycle();

    // Fill r1..r31, mark r2 and r6, then reset mid-stream.
    for (int r = 1; r < 32; r += 2) begin
      wr_en = 2'b11;
      wr_addr = {5'(r + 1), 5'(r)};
      wr_data = {32'h1000_0000 + 32'(r + 1), 32'h1000_0000 + 32'(r)};
      rd_addr = {5'(r), 5'(r + 1)};
      cycle();
    end
    idle();
    iss_en = 1; iss_rd = 5'd2; cycle();
    iss_rd = 5'd6; cycle();
    idle(); cycle();
    rst = 1; wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'hBAD0_0001};
    rd_addr = {5'd6, 5'd1};
    cycle();
    rst = 0; idle();
    for (int r = 0; r < 32; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      cycle();
    end
    rd_addr = {5'd6, 5'd2};
    #1 chk("post_rst_busy2", {31'd0, rd_busy[0]}, 32'd0);
    chk("post_rst_busy_any", {31'd0, busy_any}, 32'd0);
    chk("post_rst_r6", rd_data[63:32], 32'd0);
    cycle();

    // Randomized traffic, biased to a few registers to force collisions.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      iss_en = ($urandom_range(0, 99) < 35);
      iss_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 99) < 5);
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cycle();
    end
    rst = 0; idle();

    // Narrow four-read-port, single-write-port build.
    for (int r = 1; r < 16; r++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(r); s_wr_data = 32'hA000_0000 + 32'(r);
      @(negedge clk);
    end
    s_wr_en = 1'b0;
    s_rd_addr = {4'd12, 4'd7, 4'd3, 4'd15};
    #2;
    chk("small_p0_r15", s_rd_data[31:0],   32'hA000_000F);
    chk("small_p1_r3",  s_rd_data[63:32],  32'hA000_0003);
    chk("small_p2_r7",  s_rd_data[95:64],  32'hA000_0007);
    chk("small_p3_r12", s_rd_data[127:96], 32'hA000_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpr_file_sb
